seg_disp_sched: RTL



---
 rtl/seg_disp_sched.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/seg_disp_sched.sv
// seg_disp_sched: round-robin time-sharing of the seven-segment display data input.
// Grants one requester at a time, latches its 32-bit value onto disp_data and holds it
// for HOLD_CYCLES clocks before the next grant.
// Optional build macro SEG_DISP_SCHED_PREEMPT_EN: requester 0 becomes urgent. It aborts
// another owner's HOLD, wins every IDLE arbitration, and its preemptive grants leave
// rr_ptr untouched.
module seg_disp_sched #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned OWNER_W     = 2,
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 26,
  parameter logic [31:0] RESET_DATA  = 32'h00000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [31:0]          disp_data,
  output logic [OWNER_W-1:0]   disp_owner,
  output logic                 busy
);

  // Index space addressable by an owner id; slots >= N_REQ are never valid.
  localparam int unsigned NSlot = 2 ** OWNER_W;

  typedef enum logic [1:0] {StIdle, StGrant, StHold} state_e;

  state_e             state_q, state_d;
  logic [OWNER_W-1:0] gnt_q, gnt_d;
  logic [OWNER_W-1:0] rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        data_q, data_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
`ifdef SEG_DISP_SCHED_PREEMPT_EN
  logic               pre_q, pre_d;  // current grant came from a HOLD abort
`endif

  logic [NSlot-1:0]   valid_ext;
  logic [NSlot-1:0]   ready_ext;
  logic [OWNER_W-1:0] pick;

  assign valid_ext = NSlot'(req_valid);

  // (base + off) mod N_REQ as an owner id
  function automatic logic [OWNER_W-1:0] rr_idx(logic [OWNER_W-1:0] base, int unsigned off);
    return OWNER_W'((32'(base) + off) % N_REQ);
  endfunction

  // Round-robin pick: scan from farthest to nearest offset so the nearest valid wins.
  always_comb begin
    pick = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (valid_ext[rr_idx(rr_q, N_REQ - 1 - k)]) pick = rr_idx(rr_q, N_REQ - 1 - k);
    end
`ifdef SEG_DISP_SCHED_PREEMPT_EN
    if (req_valid[0]) pick = '0;
`endif
  end

  // Next-state logic for the IDLE -> GRANT -> HOLD cycle.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    owner_d = owner_q;
`ifdef SEG_DISP_SCHED_PREEMPT_EN
    pre_d   = pre_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          state_d = StGrant;
          gnt_d   = pick;
`ifdef SEG_DISP_SCHED_PREEMPT_EN
          pre_d   = 1'b0;
`endif
        end
      end
      StGrant: begin
        if (valid_ext[gnt_q]) begin
          data_d  = req_data[{gnt_q, 5'b00000} +: 32];
          owner_d = gnt_q;
`ifdef SEG_DISP_SCHED_PREEMPT_EN
          if (!pre_q) rr_d = rr_idx(gnt_q, 1);
`else
          rr_d    = rr_idx(gnt_q, 1);
`endif
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          state_d = StHold;
        end else begin
          // Requester withdrew; nothing is latched and the pointer stays put.
          state_d = StIdle;
        end
      end
      StHold: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - CNT_W'(1);
`ifdef SEG_DISP_SCHED_PREEMPT_EN
        if (req_valid[0] && (owner_q != '0)) begin
          state_d = StGrant;
          gnt_d   = '0;
          pre_d   = 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= RESET_DATA;
      owner_q <= '0;
`ifdef SEG_DISP_SCHED_PREEMPT_EN
      pre_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      owner_q <= owner_d;
`ifdef SEG_DISP_SCHED_PREEMPT_EN
      pre_q   <= pre_d;
`endif
    end
  end

  // Outputs decode registered state only; req_ready is high during GRANT alone.
  always_comb begin
    ready_ext = '0;
    if (state_q == StGrant) ready_ext[gnt_q] = 1'b1;
  end

  assign req_ready  = ready_ext[N_REQ-1:0];
  assign disp_data  = data_q;
  assign disp_owner = owner_q;
  assign busy       = (state_q != StIdle);

endmodule
